// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: widths, instruction fields,
// opcode values, ALU operation codes and sequencer state encoding.
package cpu_pkg;

  localparam int ALU_BIT_WIDTH        = 4;
  localparam int OPERATION_CODE_WIDTH = 3;
  localparam int INSTR_WIDTH          = 8;

  // Instruction field positions: [7:4] opcode, [3:0] operand
  localparam int OPC_MSB  = 7;
  localparam int OPC_LSB  = 4;
  localparam int OPND_MSB = 3;
  localparam int OPND_LSB = 0;

  // Opcodes
  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_XOR  = 4'h1;
  localparam logic [3:0] OPC_AND  = 4'h2;
  localparam logic [3:0] OPC_OR   = 4'h3;
  localparam logic [3:0] OPC_ADD  = 4'h4;
  localparam logic [3:0] OPC_INC  = 4'h5;
  localparam logic [3:0] OPC_DEC  = 4'h6;
  localparam logic [3:0] OPC_SUB  = 4'h7;
  localparam logic [3:0] OPC_LDA  = 4'h8;
  localparam logic [3:0] OPC_STA  = 4'h9;
  localparam logic [3:0] OPC_JMP  = 4'hA;
  localparam logic [3:0] OPC_JC   = 4'hB;
  localparam logic [3:0] OPC_LDI  = 4'hC;
  localparam logic [3:0] OPC_HLT  = 4'hF;

  // ALU operation codes (the ALU decodes these directly)
  localparam logic [2:0] OC_XOR     = 3'b001;
  localparam logic [2:0] OC_AND     = 3'b010;
  localparam logic [2:0] OC_OR      = 3'b011;
  localparam logic [2:0] OC_ADD     = 3'b100;
  localparam logic [2:0] OC_ADD_ONE = 3'b101;
  localparam logic [2:0] OC_SUB_ONE = 3'b110;
  localparam logic [2:0] OC_SUB     = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM    = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  function automatic logic [3:0] opcode_of(input logic [INSTR_WIDTH-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [3:0] operand_of(input logic [INSTR_WIDTH-1:0] instr);
    return instr[OPND_MSB:OPND_LSB];
  endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// Data-memory req/ack bus between the CPU sequencer (master) and memory (slave).
interface cpu_control_unit_if #(
  parameter int DATA_W = cpu_pkg::ALU_BIT_WIDTH,
  parameter int ADDR_W = cpu_pkg::ALU_BIT_WIDTH
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/cpu_decoder.sv
// Combinational opcode decoder: classifies an opcode into the control
// attributes the sequencer needs. Unlisted opcodes decode as NOP.
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] i_opcode,
  output logic       o_needs_mem,
  output logic       o_mem_write,
  output logic       o_alu_op,
  output logic       o_writes_carry,
  output logic       o_is_jump,
  output logic       o_is_jc,
  output logic       o_is_halt,
  output logic       o_uses_imm_one
);

  // Opcode to control attributes
  always_comb begin
    o_needs_mem    = 1'b0;
    o_mem_write    = 1'b0;
    o_alu_op       = 1'b0;
    o_writes_carry = 1'b0;
    o_is_jump      = 1'b0;
    o_is_jc        = 1'b0;
    o_is_halt      = 1'b0;
    o_uses_imm_one = 1'b0;
    case (i_opcode)
      OPC_XOR, OPC_AND, OPC_OR: begin
        o_needs_mem = 1'b1;
        o_alu_op    = 1'b1;
      end
      OPC_ADD, OPC_SUB: begin
        o_needs_mem    = 1'b1;
        o_alu_op       = 1'b1;
        o_writes_carry = 1'b1;
      end
      OPC_INC, OPC_DEC: begin
        o_alu_op       = 1'b1;
        o_writes_carry = 1'b1;
        o_uses_imm_one = 1'b1;
      end
      OPC_LDA: o_needs_mem = 1'b1;
      OPC_STA: begin
        o_needs_mem = 1'b1;
        o_mem_write = 1'b1;
      end
      OPC_JMP: o_is_jump = 1'b1;
      OPC_JC:  o_is_jc   = 1'b1;
      OPC_HLT: o_is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Sequencer for the 4-bit CPU: fetch/decode/mem/exec FSM that drives the
// external combinational ALU and runs a req/ack handshake with data memory.
// PC, instruction register, operand register, accumulator and carry live here.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int ALU_BIT_WIDTH        = cpu_pkg::ALU_BIT_WIDTH,
  parameter int OPERATION_CODE_WIDTH = cpu_pkg::OPERATION_CODE_WIDTH
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  output logic [ALU_BIT_WIDTH-1:0]        instr_addr_o,
  input  logic [INSTR_WIDTH-1:0]          instr_i,
  cpu_control_unit_if.master              mem_bus,
  output logic [ALU_BIT_WIDTH-1:0]        alu_a_o,
  output logic [ALU_BIT_WIDTH-1:0]        alu_b_o,
  output logic [OPERATION_CODE_WIDTH-1:0] alu_oc_o,
  input  logic [ALU_BIT_WIDTH-1:0]        alu_result_i,
  input  logic                            alu_carry_i,
  output logic [ALU_BIT_WIDTH-1:0]        acc_o,
  output logic                            carry_o,
  output logic                            halted_o
);

  localparam logic [ALU_BIT_WIDTH-1:0] ONE = ALU_BIT_WIDTH'(1);

  state_e                          r_state;
  logic [ALU_BIT_WIDTH-1:0]        r_pc;
  logic [INSTR_WIDTH-1:0]          r_ir;
  logic [ALU_BIT_WIDTH-1:0]        r_opnd;
  logic [ALU_BIT_WIDTH-1:0]        r_acc;
  logic                            r_carry;
  logic [OPERATION_CODE_WIDTH-1:0] r_oc;
  logic                            r_halted;
  logic                            r_req;
  logic                            r_we;
  logic [ALU_BIT_WIDTH-1:0]        r_addr;
  logic [ALU_BIT_WIDTH-1:0]        r_wdata;

  logic [3:0]                      w_opcode;
  logic [ALU_BIT_WIDTH-1:0]        w_operand;
  logic                            w_needs_mem;
  logic                            w_mem_write;
  logic                            w_alu_op;
  logic                            w_writes_carry;
  logic                            w_is_jump;
  logic                            w_is_jc;
  logic                            w_is_halt;
  logic                            w_uses_imm_one;

  // Decode works only from the registered IR, so nothing reaches the ALU
  // combinationally from the ROM data.
  assign w_opcode  = opcode_of(r_ir);
  assign w_operand = operand_of(r_ir);

  cpu_decoder u_decoder (
    .i_opcode       (w_opcode),
    .o_needs_mem    (w_needs_mem),
    .o_mem_write    (w_mem_write),
    .o_alu_op       (w_alu_op),
    .o_writes_carry (w_writes_carry),
    .o_is_jump      (w_is_jump),
    .o_is_jc        (w_is_jc),
    .o_is_halt      (w_is_halt),
    .o_uses_imm_one (w_uses_imm_one)
  );

  // Main sequencer: state, handshake, operand capture, writeback and PC update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_FETCH;
      r_pc     <= '0;
      r_ir     <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_oc     <= '0;
      r_halted <= 1'b0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          r_ir    <= instr_i;
          r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          r_oc <= w_opcode[OPERATION_CODE_WIDTH-1:0];
          if (w_is_halt) begin
            r_halted <= 1'b1;
            r_state  <= ST_HALT;
          end else if (w_needs_mem) begin
            // Bus fields are set together with req and held until ack
            r_req   <= 1'b1;
            r_we    <= w_mem_write;
            r_addr  <= w_operand;
            r_wdata <= r_acc;
            r_state <= ST_MEM;
          end else begin
            r_opnd  <= w_uses_imm_one ? ONE : w_operand;
            r_state <= ST_EXEC;
          end
        end
        ST_MEM: begin
          if (mem_bus.ack) begin
            r_req   <= 1'b0;
            r_opnd  <= mem_bus.rdata;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_alu_op) begin
            r_acc <= alu_result_i;
            if (w_writes_carry) begin
              r_carry <= alu_carry_i;
            end
          end else if (w_opcode == OPC_LDA || w_opcode == OPC_LDI) begin
            r_acc <= r_opnd;
          end
          if (w_is_jump || (w_is_jc && r_carry)) begin
            r_pc <= w_operand;
          end else begin
            r_pc <= r_pc + ONE;
          end
          r_state <= ST_FETCH;
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign instr_addr_o  = r_pc;
  assign alu_a_o       = r_acc;
  assign alu_b_o       = r_opnd;
  assign alu_oc_o      = r_oc;
  assign acc_o         = r_acc;
  assign carry_o       = r_carry;
  assign halted_o      = r_halted;
  assign mem_bus.req   = r_req;
  assign mem_bus.we    = r_we;
  assign mem_bus.addr  = r_addr;
  assign mem_bus.wdata = r_wdata;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit with ROM, data memory (programmable
// ack delay) and a behavioural ALU attached.
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] instr_addr;
  logic [7:0] instr;
  logic [3:0] alu_a, alu_b, acc;
  logic [2:0] alu_oc;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       carry, halted;

  logic [7:0] rom [16];
  logic [3:0] dmem [16];
  int         ack_delay = 0;
  int         ack_cnt;

  int checks = 0;
  int errors = 0;

  // Bus monitor state
  int         req_cycles = 0;
  int         unstable = 0;
  int         wr_count = 0;
  logic [3:0] last_wr_addr = '0;
  logic [3:0] last_wr_data = '0;
  logic       prev_req = 1'b0;
  logic       prev_we = 1'b0;
  logic [3:0] prev_addr = '0;
  logic [3:0] prev_wdata = '0;

  cpu_control_unit_if #(.DATA_W(4), .ADDR_W(4)) mem_bus ();

  cpu_control_unit dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .instr_addr_o (instr_addr),
    .instr_i      (instr),
    .mem_bus      (mem_bus),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_oc_o     (alu_oc),
    .alu_result_i (alu_result),
    .alu_carry_i  (alu_carry),
    .acc_o        (acc),
    .carry_o      (carry),
    .halted_o     (halted)
  );

  always #5 clk = ~clk;

  assign instr = rom[instr_addr];
  assign mem_bus.rdata = dmem[mem_bus.addr];
  assign mem_bus.ack = mem_bus.req && (ack_cnt == ack_delay);

  // Behavioural ALU: SUB carry is the borrow (a < b)
  always_comb begin
    logic [4:0] t;
    t = 5'd0;
    case (alu_oc)
      3'b001: t = {1'b0, alu_a ^ alu_b};
      3'b010: t = {1'b0, alu_a & alu_b};
      3'b011: t = {1'b0, alu_a | alu_b};
      3'b100, 3'b101: t = {1'b0, alu_a} + {1'b0, alu_b};
      3'b110, 3'b111: t = {1'b0, alu_a} - {1'b0, alu_b};
      default: t = 5'd0;
    endcase
    alu_result = t[3:0];
    alu_carry  = t[4];
  end

  // Wait-state counter for the memory model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_cnt <= 0;
    else if (mem_bus.req && !mem_bus.ack) ack_cnt <= ack_cnt + 1;
    else ack_cnt <= 0;
  end

  // Bus monitor: req cycles, field stability while req high, completed writes
  always @(posedge clk) begin
    if (rst_n && mem_bus.req) begin
      req_cycles <= req_cycles + 1;
      if (prev_req && (mem_bus.we !== prev_we || mem_bus.addr !== prev_addr ||
                       mem_bus.wdata !== prev_wdata))
        unstable <= unstable + 1;
      if (mem_bus.ack && mem_bus.we) begin
        wr_count     <= wr_count + 1;
        last_wr_addr <= mem_bus.addr;
        last_wr_data <= mem_bus.wdata;
      end
    end
    prev_req   <= rst_n && mem_bus.req;
    prev_we    <= mem_bus.we;
    prev_addr  <= mem_bus.addr;
    prev_wdata <= mem_bus.wdata;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_rom_nop();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
  endtask

  int base_req, base_wr, base_unst;

  initial begin
    load_rom_nop();
    for (int i = 0; i < 16; i++) dmem[i] = 4'h0;
    dmem[3] = 4'hA;
    dmem[4] = 4'h3;

    // Reset state
    rst_n = 1'b0;
    run(2);
    check("rst_pc",     8'(instr_addr), 8'h0);
    check("rst_acc",    8'(acc),        8'h0);
    check("rst_carry",  8'(carry),      8'h0);
    check("rst_req",    8'(mem_bus.req), 8'h0);
    check("rst_we",     8'(mem_bus.we),  8'h0);
    check("rst_halted", 8'(halted),     8'h0);
    check("rst_oc",     8'(alu_oc),     8'h0);
    check("rst_b",      8'(alu_b),      8'h0);
    rst_n = 1'b1;

    // LDI 7; ADD 1
    rom[0] = 8'hC7; rom[1] = 8'h50; rom[2] = 8'hF0;
    base_req = req_cycles;
    run(6);
    check("t1_acc",   8'(acc),        8'h8);
    check("t1_carry", 8'(carry),      8'h0);
    check("t1_pc",    8'(instr_addr), 8'h2);
    check("t1_noreq", 8'(req_cycles - base_req), 8'h0);

    // LDI F; ADD 1; JC 9 with carry set
    load_rom_nop();
    rom[0] = 8'hCF; rom[1] = 8'h50; rom[2] = 8'hB9;
    do_reset();
    run(6);
    check("t2_acc",   8'(acc),        8'h0);
    check("t2_carry", 8'(carry),      8'h1);
    run(3);
    check("t2_jc_pc", 8'(instr_addr), 8'h9);

    // LDI E; ADD 1; JC 9 with carry clear
    rom[0] = 8'hCE;
    do_reset();
    run(6);
    check("t2b_acc",   8'(acc),        8'hF);
    check("t2b_carry", 8'(carry),      8'h0);
    run(3);
    check("t2b_pc",    8'(instr_addr), 8'h3);

    // LDA 3, ack after two wait cycles
    load_rom_nop();
    rom[0] = 8'h83;
    ack_delay = 2;
    do_reset();
    base_req = req_cycles;
    run(3);
    check("t3_req",   8'(mem_bus.req),  8'h1);
    check("t3_addr",  8'(mem_bus.addr), 8'h3);
    check("t3_we",    8'(mem_bus.we),   8'h0);
    run(2);
    check("t3_pc5",   8'(instr_addr), 8'h0);
    run(1);
    check("t3_pc6",   8'(instr_addr), 8'h1);
    check("t3_acc",   8'(acc),        8'hA);
    check("t3_reqcy", 8'(req_cycles - base_req), 8'h3);

    // LDI 6; STA 5, one wait cycle
    load_rom_nop();
    rom[0] = 8'hC6; rom[1] = 8'h95; rom[2] = 8'hF0;
    ack_delay = 1;
    do_reset();
    base_wr = wr_count;
    base_unst = unstable;
    run(5);
    check("t4_req",   8'(mem_bus.req),   8'h1);
    check("t4_we",    8'(mem_bus.we),    8'h1);
    check("t4_addr",  8'(mem_bus.addr),  8'h5);
    check("t4_wdata", 8'(mem_bus.wdata), 8'h6);
    run(3);
    check("t4_pc",     8'(instr_addr),        8'h2);
    check("t4_acc",    8'(acc),               8'h6);
    check("t4_carry",  8'(carry),             8'h0);
    check("t4_wrcnt",  8'(wr_count - base_wr), 8'h1);
    check("t4_wraddr", 8'(last_wr_addr),      8'h5);
    check("t4_wrdata", 8'(last_wr_data),      8'h6);
    check("t4_stable", 8'(unstable - base_unst), 8'h0);

    // LDI F; ADD 1 (carry=1); XOR mem3 keeps carry; SUB mem4 rewrites carry
    load_rom_nop();
    rom[0] = 8'hCF; rom[1] = 8'h50; rom[2] = 8'h13; rom[3] = 8'h74;
    ack_delay = 0;
    do_reset();
    run(10);
    check("t5_xor_acc", 8'(acc),   8'hA);
    check("t5_xor_c",   8'(carry), 8'h1);
    run(4);
    check("t5_sub_acc", 8'(acc),        8'h7);
    check("t5_sub_c",   8'(carry),      8'h0);
    check("t5_pc",      8'(instr_addr), 8'h4);

    // NOP sweep wraps PC 15 -> 0, then HLT at address 1
    load_rom_nop();
    do_reset();
    run(45);
    check("t6_pc15", 8'(instr_addr), 8'hF);
    run(3);
    check("t6_wrap", 8'(instr_addr), 8'h0);
    rom[1] = 8'hF0;
    run(3);
    check("t6_pc1",  8'(instr_addr), 8'h1);
    run(1);
    check("t6_hlt_dec", 8'(halted), 8'h0);
    run(1);
    check("t6_halted", 8'(halted), 8'h1);
    base_req = req_cycles;
    run(20);
    check("t6_hlt_pc",  8'(instr_addr), 8'h1);
    check("t6_hlt_req", 8'(req_cycles - base_req), 8'h0);
    check("t6_still",   8'(halted), 8'h1);

    // Reset asserted while a memory read is waiting for ack
    load_rom_nop();
    rom[0] = 8'hCF; rom[1] = 8'h50; rom[2] = 8'hC5; rom[3] = 8'h83;
    ack_delay = 10;
    do_reset();
    run(9);
    check("t7_acc_pre", 8'(acc),   8'h5);
    check("t7_c_pre",   8'(carry), 8'h1);
    run(2);
    check("t7_req_pre", 8'(mem_bus.req), 8'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_req",    8'(mem_bus.req), 8'h0);
    check("t7_acc",    8'(acc),         8'h0);
    check("t7_pc",     8'(instr_addr),  8'h0);
    check("t7_carry",  8'(carry),       8'h0);
    check("t7_halted", 8'(halted),      8'h0);
    rom[0] = 8'hC3;
    ack_delay = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run(3);
    check("t7_refetch_pc",  8'(instr_addr), 8'h1);
    check("t7_refetch_acc", 8'(acc),        8'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
